// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises IF fetches and MEM data accesses onto
// one memory port and produces the pipeline iwait/dwait stalls.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter bit D_PRIORITY = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_read,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                iwait,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wmask,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                dwait,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_byte_enable,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_resp
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        I_ACC = 2'd1,
        D_ACC = 2'd2
    } state_t;

    state_t            state;
    state_t            state_n;
    logic              i_done;
    logic              d_done;
    logic [DATA_W-1:0] i_buf;
    logic [DATA_W-1:0] d_buf;
    logic              i_req;
    logic              d_req;
    logic              i_pend;
    logic              d_pend;
    logic              i_fin;
    logic              d_fin;
    logic              advance;

    assign i_req   = i_read;
    assign d_req   = d_read | d_write;
    assign i_pend  = i_req & ~i_done;
    assign d_pend  = d_req & ~d_done;
    assign i_fin   = (state == I_ACC) & mem_resp;
    assign d_fin   = (state == D_ACC) & mem_resp;
    assign iwait   = i_pend & ~i_fin;
    assign dwait   = d_pend & ~d_fin;
    assign advance = ~iwait & ~dwait;
    assign i_rdata = i_fin ? mem_rdata : i_buf;
    assign d_rdata = d_fin ? mem_rdata : d_buf;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state: pick a pending side in IDLE, return to IDLE on resp
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                priority case (1'b1)
                    i_pend & d_pend:
                        state_n = D_PRIORITY ? D_ACC : I_ACC;
                    d_pend:
                        state_n = D_ACC;
                    i_pend:
                        state_n = I_ACC;
                    default:
                        state_n = IDLE;
                endcase
            end
            I_ACC: if (mem_resp) state_n = IDLE;
            D_ACC: if (mem_resp) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Port drive from the side currently being served
    always_comb begin
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = '0;
        mem_wdata       = '0;
        mem_byte_enable = '1;
        unique case (state)
            I_ACC: begin
                mem_read    = 1'b1;
                mem_address = i_addr;
            end
            D_ACC: begin
                mem_read    = ~d_write;
                mem_write   = d_write;
                mem_address = d_addr;
                mem_wdata   = d_wdata;
                if (d_write) mem_byte_enable = d_wmask;
            end
            default: ;
        endcase
    end

    // Completion flags and result buffers; a pipeline advance wins
    always_ff @(posedge clk) begin
        if (rst) begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            i_buf  <= '0;
            d_buf  <= '0;
        end else begin
            if (i_fin) begin
                i_buf  <= mem_rdata;
                i_done <= 1'b1;
            end
            if (d_fin) begin
                if (~d_write) d_buf <= mem_rdata;
                d_done <= 1'b1;
            end
            if (advance) begin
                i_done <= 1'b0;
                d_done <= 1'b0;
            end
        end
    end

endmodule
